// File: rtl/sandbox_pkg.sv
// Shared opcode, status-bit and FSM definitions for the sandbox command engine.
package sandbox_pkg;

    localparam logic [7:0] OP_NOP      = 8'h00;
    localparam logic [7:0] OP_ECHO     = 8'h01;
    localparam logic [7:0] OP_LOAD     = 8'h02;
    localparam logic [7:0] OP_ADD      = 8'h03;
    localparam logic [7:0] OP_MUL      = 8'h04;
    localparam logic [7:0] OP_READ     = 8'h05;
    localparam logic [7:0] OP_POPCOUNT = 8'h06;

    localparam int ST_ERR   = 7;
    localparam int ST_CARRY = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_EXEC,
        S_ITER,
        S_REPLY,
        S_WAIT_TX_HI,
        S_WAIT_TX_LO
    } state_e;

    typedef enum logic {
        ALU_MUL,
        ALU_POPCNT
    } alu_mode_e;

endpackage

// File: rtl/sandbox_iter_alu.sv
// 32-cycle shift engine for MUL (shift-add) and POPCOUNT.
// done is high during the final step; result is complete on the following cycle.
module sandbox_iter_alu
    import sandbox_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  alu_mode_e   mode,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        done,
    output logic [31:0] result
);

    logic        busy_q, busy_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] res_q, res_d;
    alu_mode_e   mode_q, mode_d;

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        a_d    = a_q;
        b_d    = b_q;
        res_d  = res_q;
        mode_d = mode_q;
        if (start) begin
            busy_d = 1'b1;
            cnt_d  = 5'd0;
            a_d    = op_a;
            b_d    = op_b;
            res_d  = 32'd0;
            mode_d = mode;
        end else if (busy_q) begin
            // One multiplier/operand bit is consumed per cycle, LSB first.
            if (mode_q == ALU_MUL) begin
                if (b_q[0]) res_d = res_q + a_q;
            end else begin
                res_d = res_q + {31'd0, b_q[0]};
            end
            a_d   = {a_q[30:0], 1'b0};
            b_d   = {1'b0, b_q[31:1]};
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= 5'd0;
            a_q    <= 32'd0;
            b_q    <= 32'd0;
            res_q  <= 32'd0;
            mode_q <= ALU_MUL;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            a_q    <= a_d;
            b_q    <= b_d;
            res_q  <= res_d;
            mode_q <= mode_d;
        end
    end

    assign done   = busy_q && (cnt_q == 5'd31);
    assign result = res_q;

endmodule

// File: rtl/sandbox_command_engine.sv
// Command engine behind the wide UART block: executes one command per received word
// against a 32-bit accumulator and returns a status/data reply.
// Opcode 0x06 POPCOUNT exists only when SANDBOX_CMD_POPCOUNT_EN is defined.
module sandbox_command_engine
    import sandbox_pkg::*;
#(
    parameter int LED_STRETCH = 1200000,
    parameter int TX_TIMEOUT  = 65535
) (
    input  logic        masterClock,
    input  logic        reset,
    input  logic        dataReceived,
    input  logic [7:0]  control,
    input  logic [31:0] inputData,
    input  logic        transmitting,
    output logic        clearDR,
    output logic        transmitData,
    output logic [7:0]  status,
    output logic [31:0] outputData,
    output logic        rxIndicator
);

    localparam int LW = $clog2(LED_STRETCH + 1);
    localparam int TW = $clog2(TX_TIMEOUT + 1);

    state_e      state_q, state_d;
    logic [7:0]  ctrl_q, ctrl_d;
    logic [31:0] operand_q, operand_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] result_q, result_d;
    logic        carry_q, carry_d;
    logic        err_q, err_d;
    logic        tx_err_q, tx_err_d;
    logic        iter_q, iter_d;
    logic [3:0]  seq_q, seq_d;
    logic [TW-1:0] tx_cnt_q, tx_cnt_d;
    logic [LW-1:0] led_cnt_q, led_cnt_d;
    logic        clear_dr_q, clear_dr_d;
    logic        transmit_data_q, transmit_data_d;
    logic [7:0]  status_q, status_d;
    logic [31:0] output_data_q, output_data_d;

    logic [32:0] sum;
    logic        alu_start;
    alu_mode_e   alu_mode;
    logic        alu_done;
    logic [31:0] alu_result;

    sandbox_iter_alu u_iter_alu (
        .clk    (masterClock),
        .reset  (reset),
        .start  (alu_start),
        .mode   (alu_mode),
        .op_a   (acc_q),
        .op_b   (operand_q),
        .done   (alu_done),
        .result (alu_result)
    );

    always_comb begin
        // NOTE: every signal gets its default before the case so no path can infer a latch.
        state_d         = state_q;
        ctrl_d          = ctrl_q;
        operand_d       = operand_q;
        acc_d           = acc_q;
        result_d        = result_q;
        carry_d         = carry_q;
        err_d           = err_q;
        tx_err_d        = tx_err_q;
        iter_d          = iter_q;
        seq_d           = seq_q;
        tx_cnt_d        = tx_cnt_q;
        status_d        = status_q;
        output_data_d   = output_data_q;
        clear_dr_d      = 1'b0;
        transmit_data_d = 1'b0;
        alu_start       = 1'b0;
        alu_mode        = ALU_MUL;
        sum             = {1'b0, acc_q} + {1'b0, operand_q};
        led_cnt_d       = (led_cnt_q != '0) ? led_cnt_q - LW'(1) : led_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (dataReceived) begin
                    ctrl_d     = control;
                    operand_d  = inputData;
                    err_d      = 1'b0;
                    clear_dr_d = 1'b1;
                    led_cnt_d  = LW'(LED_STRETCH);
                    state_d    = S_CAPTURE;
                end
            end
            S_CAPTURE: state_d = S_EXEC;
            S_EXEC: begin
                iter_d  = 1'b0;
                state_d = S_REPLY;
                case (ctrl_q)
                    OP_NOP:  state_d = S_IDLE;
                    OP_ECHO: result_d = operand_q;
                    OP_LOAD: begin
                        acc_d    = operand_q;
                        result_d = operand_q;
                    end
                    OP_ADD: begin
                        {carry_d, acc_d} = sum;
                        result_d         = sum[31:0];
                    end
                    OP_MUL: begin
                        alu_start = 1'b1;
                        alu_mode  = ALU_MUL;
                        iter_d    = 1'b1;
                        state_d   = S_ITER;
                    end
                    OP_READ: result_d = acc_q;
`ifdef SANDBOX_CMD_POPCOUNT_EN
                    OP_POPCOUNT: begin
                        alu_start = 1'b1;
                        alu_mode  = ALU_POPCNT;
                        iter_d    = 1'b1;
                        state_d   = S_ITER;
                    end
`endif
                    default: begin
                        err_d    = 1'b1;
                        result_d = operand_q;
                    end
                endcase
            end
            S_ITER: begin
                if (alu_done) state_d = S_REPLY;
            end
            S_REPLY: begin
                status_d           = '0;
                status_d[ST_ERR]   = err_q | tx_err_q;
                status_d[ST_CARRY] = carry_q;
                status_d[3:0]      = seq_q;
                output_data_d      = iter_q ? alu_result : result_q;
                if (iter_q && (ctrl_q == OP_MUL)) acc_d = alu_result;
                seq_d           = seq_q + 4'd1;
                tx_err_d        = 1'b0;
                transmit_data_d = 1'b1;
                tx_cnt_d        = '0;
                state_d         = S_WAIT_TX_HI;
            end
            S_WAIT_TX_HI: begin
                if (transmitting) begin
                    state_d = S_WAIT_TX_LO;
                end else if (tx_cnt_q == TW'(TX_TIMEOUT - 1)) begin
                    // The lost reply is reported through status[7] of the next reply.
                    tx_err_d = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + TW'(1);
                end
            end
            S_WAIT_TX_LO: begin
                if (!transmitting) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge masterClock) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q         <= S_IDLE;
            ctrl_q          <= '0;
            operand_q       <= '0;
            acc_q           <= '0;
            result_q        <= '0;
            carry_q         <= 1'b0;
            err_q           <= 1'b0;
            tx_err_q        <= 1'b0;
            iter_q          <= 1'b0;
            seq_q           <= '0;
            tx_cnt_q        <= '0;
            led_cnt_q       <= '0;
            clear_dr_q      <= 1'b0;
            transmit_data_q <= 1'b0;
            status_q        <= '0;
            output_data_q   <= '0;
        end else begin
            state_q         <= state_d;
            ctrl_q          <= ctrl_d;
            operand_q       <= operand_d;
            acc_q           <= acc_d;
            result_q        <= result_d;
            carry_q         <= carry_d;
            err_q           <= err_d;
            tx_err_q        <= tx_err_d;
            iter_q          <= iter_d;
            seq_q           <= seq_d;
            tx_cnt_q        <= tx_cnt_d;
            led_cnt_q       <= led_cnt_d;
            clear_dr_q      <= clear_dr_d;
            transmit_data_q <= transmit_data_d;
            status_q        <= status_d;
            output_data_q   <= output_data_d;
        end
    end

    assign clearDR      = clear_dr_q;
    assign transmitData = transmit_data_q;
    assign status       = status_q;
    assign outputData   = output_data_q;
    assign rxIndicator  = (led_cnt_q != '0);

endmodule

// File: tb/tb_sandbox_command_engine.sv
// Scoreboard bench for sandbox_command_engine: a host driver issues commands, a reference
// model queues the expected replies, and a monitor checks every transmitData pulse.
module tb_sandbox_command_engine;
    import sandbox_pkg::*;

    localparam int LED_STRETCH = 50;
    localparam int TX_TIMEOUT  = 200;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dataReceived = 1'b0;
    logic [7:0]  control = 8'h00;
    logic [31:0] inputData = 32'h0;
    logic        transmitting = 1'b0;
    logic        clearDR, transmitData, rxIndicator;
    logic [7:0]  status;
    logic [31:0] outputData;

    sandbox_command_engine #(
        .LED_STRETCH (LED_STRETCH),
        .TX_TIMEOUT  (TX_TIMEOUT)
    ) dut (
        .masterClock  (clk),
        .reset        (reset),
        .dataReceived (dataReceived),
        .control      (control),
        .inputData    (inputData),
        .transmitting (transmitting),
        .clearDR      (clearDR),
        .transmitData (transmitData),
        .status       (status),
        .outputData   (outputData),
        .rxIndicator  (rxIndicator)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  status;
        logic [31:0] data;
        int          lat;
        int          issue;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   clr_cnt = 0;
    int   tx_cnt = 0;
    int   last_clr_cyc = 0;
    int   last_tx_cyc = 0;
    int   last_drop_cyc = 0;
    bit   mute = 1'b0;
    bit   uart_busy = 1'b0;

    // Reference model state
    logic [31:0] m_acc = 32'h0;
    bit          m_carry = 1'b0;
    int          m_seq = 0;
    bit          m_pend_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: counts acknowledges and checks every reply against the scoreboard.
    always @(negedge clk) begin
        if (clearDR) begin
            clr_cnt++;
            last_clr_cyc = cyc;
        end
        if (transmitData) begin
            tx_cnt++;
            last_tx_cyc = cyc;
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_reply: got status 0x%0h data 0x%0h with no reply pending", status, outputData);
            end else begin
                mon_e = sb_q.pop_front();
                check("status", status, mon_e.status);
                check("outputData", outputData, mon_e.data);
                if (mon_e.lat >= 0) check("latency", cyc - mon_e.issue, mon_e.lat);
            end
        end
    end

    // UART transmitter stand-in: raises transmitting after a short random delay.
    initial begin
        forever begin
            @(negedge clk);
            if (transmitData && !mute) begin
                uart_busy = 1'b1;
                repeat ($urandom_range(0, 2)) @(negedge clk);
                transmitting = 1'b1;
                repeat ($urandom_range(1, 5)) @(negedge clk);
                transmitting = 1'b0;
                last_drop_cyc = cyc;
                uart_busy = 1'b0;
            end
        end
    end

    task automatic model_cmd(input logic [7:0] op, input logic [31:0] d, input bit timed);
        exp_t e;
        bit reply = 1'b1;
        bit err = 1'b0;
        logic [31:0] res = d;
        int lat = 4;
        longint unsigned wide;
        case (op)
            OP_NOP:  reply = 1'b0;
            OP_ECHO: res = d;
            OP_LOAD: begin
                m_acc = d;
                res = d;
            end
            OP_ADD: begin
                wide = longint'(m_acc) + longint'(d);
                m_carry = (wide > 64'hFFFF_FFFF);
                m_acc = 32'(wide);
                res = m_acc;
            end
            OP_MUL: begin
                wide = longint'(m_acc) * longint'(d);
                m_acc = 32'(wide);
                res = m_acc;
                lat = 36;
            end
            OP_READ: res = m_acc;
`ifdef SANDBOX_CMD_POPCOUNT_EN
            OP_POPCOUNT: begin
                res = 32'($countones(d));
                lat = 36;
            end
`endif
            default: err = 1'b1;
        endcase
        if (reply) begin
            e.status = {err | m_pend_err, m_carry, 2'b00, 4'(m_seq)};
            e.data   = res;
            e.lat    = timed ? lat : -1;
            e.issue  = cyc;
            sb_q.push_back(e);
            m_seq = (m_seq + 1) % 16;
            m_pend_err = 1'b0;
        end
    endtask

    task automatic wait_clr();
        bit ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (clearDR) ok = 1'b1;
        end
        check("clearDR_seen", ok, 1);
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !uart_busy && !transmitting && !transmitData) done = 1'b1;
        end
        check("reply_drained", done, 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [31:0] d);
        int c0;
        @(negedge clk);
        model_cmd(op, d, 1'b1);
        c0 = clr_cnt;
        control = op;
        inputData = d;
        dataReceived = 1'b1;
        wait_clr();
        dataReceived = 1'b0;
        wait_idle();
        check("clearDR_pulses", clr_cnt - c0, 1);
    endtask

    initial begin
        int c0;
        int t;
        int r;
        logic [7:0] op;

        repeat (3) @(negedge clk);
        check("rst_clearDR", clearDR, 0);
        check("rst_transmitData", transmitData, 0);
        check("rst_status", status, 0);
        check("rst_outputData", outputData, 0);
        check("rst_rxIndicator", rxIndicator, 0);
        reset = 1'b0;

        send_cmd(OP_LOAD, 32'h0000_0005);
        send_cmd(OP_MUL, 32'h0000_0007);
        send_cmd(OP_LOAD, 32'hFFFF_FFFF);
        send_cmd(OP_ADD, 32'h0000_0002);
        send_cmd(OP_ADD, 32'h0000_0001);
        send_cmd(8'h7F, 32'hDEAD_BEEF);
        send_cmd(OP_READ, 32'h0);
        send_cmd(OP_POPCOUNT, 32'hF0F0_000F);
        send_cmd(OP_NOP, 32'h0);
        for (int i = 0; i < 17; i++) send_cmd(OP_ECHO, $urandom);

        // LED stretch length measured from the acknowledge.
        send_cmd(OP_ECHO, 32'h0000_1234);
        for (int i = 0; i < 200 && rxIndicator; i++) @(negedge clk);
        check("led_stretch", cyc - last_clr_cyc, LED_STRETCH);

        // dataReceived held high across a reply: second command waits for WAIT_TX_LO exit.
        @(negedge clk);
        model_cmd(OP_ECHO, 32'hA5A5_0001, 1'b1);
        c0 = clr_cnt;
        control = OP_ECHO;
        inputData = 32'hA5A5_0001;
        dataReceived = 1'b1;
        wait_clr();
        model_cmd(OP_ECHO, 32'h5A5A_0002, 1'b0);
        inputData = 32'h5A5A_0002;
        wait_clr();
        t = cyc;
        dataReceived = 1'b0;
        check("held_ack_after_tx_lo", t - last_drop_cyc, 2);
        wait_idle();
        check("held_clearDR_pulses", clr_cnt - c0, 2);

        // transmitting never rises: engine gives up and flags the next reply.
        mute = 1'b1;
        @(negedge clk);
        model_cmd(OP_ECHO, 32'hC0FF_EE00, 1'b1);
        control = OP_ECHO;
        inputData = 32'hC0FF_EE00;
        dataReceived = 1'b1;
        wait_clr();
        dataReceived = 1'b0;
        for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
        check("muted_reply_seen", sb_q.size(), 0);
        m_pend_err = 1'b1;
        model_cmd(OP_ECHO, 32'h0000_BEEF, 1'b0);
        inputData = 32'h0000_BEEF;
        dataReceived = 1'b1;
        wait_clr();
        t = cyc - last_tx_cyc;
        mute = 1'b0;
        dataReceived = 1'b0;
        check("timeout_not_early", t >= TX_TIMEOUT, 1);
        check("timeout_not_late", t <= TX_TIMEOUT + 2, 1);
        wait_idle();
        send_cmd(OP_ECHO, 32'h0000_0001);

        // Reset in the middle of a MUL aborts it without a reply.
        @(negedge clk);
        control = OP_MUL;
        inputData = 32'h1234_5678;
        dataReceived = 1'b1;
        wait_clr();
        dataReceived = 1'b0;
        repeat (10) @(negedge clk);
        c0 = tx_cnt;
        reset = 1'b1;
        @(negedge clk);
        check("midrst_clearDR", clearDR, 0);
        check("midrst_transmitData", transmitData, 0);
        check("midrst_status", status, 0);
        check("midrst_outputData", outputData, 0);
        check("midrst_rxIndicator", rxIndicator, 0);
        reset = 1'b0;
        m_acc = 32'h0;
        m_carry = 1'b0;
        m_seq = 0;
        m_pend_err = 1'b0;
        repeat (60) @(negedge clk);
        check("no_tx_after_reset", tx_cnt - c0, 0);
        send_cmd(OP_READ, 32'h0);

        // Randomized command stream.
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            if (r <= 6) op = 8'(r);
            else op = 8'($urandom_range(7, 255));
            send_cmd(op, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
